// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [2:0]  OP_HALT   = 3'b111;
  localparam logic [11:0] HALT_WORD = 12'hE00;

  localparam int DEF_DEBOUNCE_CYCLES = 250000;
  localparam int DEF_IMEM_DEPTH      = 16;
  localparam int DEF_INSTR_W         = 12;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and
// rising-edge press pulse of the accepted level.
module btn_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // The counter only advances while the synchronized input disagrees with
  // the accepted level; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 != level) begin
        if (cnt == CW'(CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/instr_fetch_unit.sv
// Processor front end: debounced buttons, 16-entry instruction memory with
// program counter, and manual / load / auto issue modes.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int IMEM_DEPTH      = DEF_IMEM_DEPTH,
  parameter int INSTR_W         = DEF_INSTR_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          leftBtnRaw,
  input  logic                          rightBtnRaw,
  input  logic                          switchEn,
  input  logic                          loadEn,
  input  logic [INSTR_W-1:0]            switchInstr,
  output logic [INSTR_W-1:0]            instructions,
  output logic                          leftBtnDebounce,
  output logic                          rightBtnDebounce,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc,
  output logic                          halted
);

  localparam int                 PCW        = $clog2(IMEM_DEPTH);
  localparam logic [INSTR_W-1:0] RESET_WORD = {OP_HALT, {(INSTR_W - 3){1'b0}}};

  fetch_state_t       state;
  fetch_state_t       next_state;
  logic               lp;
  logic               rp;
  logic               do_manual;
  logic               do_load;
  logic               do_issue;
  logic               do_halt;
  logic [INSTR_W-1:0] fetched;
  logic [INSTR_W-1:0] imem [IMEM_DEPTH];

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_left_db (
    .clk   (clk),
    .reset (reset),
    .raw   (leftBtnRaw),
    .press (lp)
  );

  btn_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_right_db (
    .clk   (clk),
    .reset (reset),
    .raw   (rightBtnRaw),
    .press (rp)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Presses only act in IDLE; everywhere else they are simply dropped.
  always_comb begin
    next_state = state;
    do_manual  = 1'b0;
    do_load    = 1'b0;
    do_issue   = 1'b0;
    do_halt    = 1'b0;
    case (state)
      IDLE: begin
        if (!switchEn) begin
          if (lp) begin
            if (loadEn) do_load   = 1'b1;
            else        do_manual = 1'b1;
          end
        end else if (rp) begin
          next_state = FETCH;
        end
      end
      FETCH: next_state = ISSUE;
      ISSUE: begin
        if (fetched[INSTR_W-1 -: 3] == OP_HALT) begin
          do_halt    = 1'b1;
          next_state = HALT;
        end else begin
          do_issue   = 1'b1;
          next_state = IDLE;
        end
      end
      HALT: begin
        if (!switchEn) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Reset preloads every memory entry with HALT so an unloaded program stops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      instructions     <= '0;
      leftBtnDebounce  <= 1'b0;
      rightBtnDebounce <= 1'b0;
      pc               <= '0;
      halted           <= 1'b0;
      fetched          <= '0;
      for (int i = 0; i < IMEM_DEPTH; i++) imem[i] <= RESET_WORD;
    end else begin
      leftBtnDebounce  <= do_manual;
      rightBtnDebounce <= do_issue;
      if (do_manual) instructions <= switchInstr;
      if (do_load) begin
        imem[pc] <= switchInstr;
        pc       <= pc + PCW'(1);
      end
      if (state == FETCH) fetched <= imem[pc];
      if (do_issue) begin
        instructions <= fetched;
        pc           <= pc + PCW'(1);
      end
      if (do_halt)                         halted <= 1'b1;
      else if (state == HALT && !switchEn) halted <= 1'b0;
    end
  end

endmodule
